cprv_hazard_ctrl: RTL and testbench

Scoreboard-based RAW hazard interlock between the IF stage and `cprv_id_stage` of the cprv64g pipeline. It tracks which architectural registers have a write in flight, from ID issue to WB retire. It blocks the IF→ID valid/ready handshake while the instruction at ID reads a pending register. It also stalls when a new write would overflow that register's in-flight counter, and counts stall cycles for performance monitoring.

---
 rtl/cprv_hazard_ctrl.sv | 54 +++++
 tb/tb_cprv_hazard_ctrl.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/cprv_hazard_ctrl.sv
// cprv_hazard_ctrl: scoreboard RAW interlock between IF and ID with a saturating stall-cycle counter
// Ports: clk, rst_n (async, active-low); valid_if_i/ready_if_o/instr_data_if_i IF handshake;
//   valid_id_o/ready_id_i ID handshake; wb_valid_i/wb_rd_addr_i retiring register write;
//   flush_i clears in-flight tracking; stall_o hazard this cycle; stall_cnt_o stall-cycle count.
module cprv_hazard_ctrl #(
  parameter int INSTR_WIDTH     = 32,
  parameter int CNT_WIDTH       = 2,
  parameter int STALL_CNT_WIDTH = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       valid_if_i,
  output logic                       ready_if_o,
  input  logic [INSTR_WIDTH-1:0]     instr_data_if_i,
  output logic                       valid_id_o,
  input  logic                       ready_id_i,
  input  logic                       wb_valid_i,
  input  logic [4:0]                 wb_rd_addr_i,
  input  logic                       flush_i,
  output logic                       stall_o,
  output logic [STALL_CNT_WIDTH-1:0] stall_cnt_o
);
  logic [6:0] opc;
  logic [4:0] rs1, rs2, rd;
  logic use1, use2, wrd, hazard, issue;
  logic [31:0] inc, dec;
  // entry 0 is never written after reset, so reads of x0 always see zero
  logic [31:0][CNT_WIDTH-1:0] pend;
  assign opc = instr_data_if_i[6:0];
  assign rs1 = instr_data_if_i[19:15];
  assign rs2 = instr_data_if_i[24:20];
  assign rd  = instr_data_if_i[11:7];
  assign wrd  = opc inside {7'b0110011, 7'b0111011, 7'b0010011, 7'b0011011, 7'b0000011};
  assign use2 = opc inside {7'b0110011, 7'b0111011, 7'b0100011};
  assign use1 = wrd | use2;
  assign hazard = valid_if_i & ((use1 & |pend[rs1]) | (use2 & |pend[rs2]) |
                                (wrd & |rd & &pend[rd]));
  assign stall_o    = hazard;
  assign valid_id_o = valid_if_i & ~hazard;
  assign ready_if_o = ready_id_i & ~hazard;
  assign issue      = valid_id_o & ready_id_i;
  assign inc = (issue & wrd) ? 32'd1 << rd : '0;
  assign dec = wb_valid_i ? 32'd1 << wb_rd_addr_i : '0;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      pend        <= '0;
      stall_cnt_o <= '0;
    end else begin
      if (stall_o && ~&stall_cnt_o) stall_cnt_o <= stall_cnt_o + 1'b1;
      for (int r = 1; r < 32; r++)
        if (flush_i) pend[r] <= '0;
        else if (inc[r] != (dec[r] && |pend[r])) pend[r] <= inc[r] ? pend[r] + 1'b1 : pend[r] - 1'b1;
    end
endmodule

// File: tb/tb_cprv_hazard_ctrl.sv
// tb_cprv_hazard_ctrl: directed and random checks of cprv_hazard_ctrl against a scoreboard model
module tb_cprv_hazard_ctrl;
  localparam int SW   = 6;
  localparam int MAXP = 3;
  localparam int SMAX = 63;
  logic clk = 0, rst_n = 0;
  logic valid_if_i = 0, ready_id_i = 0, wb_valid_i = 0, flush_i = 0;
  logic [31:0] instr_data_if_i = 0;
  logic [4:0] wb_rd_addr_i = 0;
  logic ready_if_o, valid_id_o, stall_o;
  logic [SW-1:0] stall_cnt_o;
  int checks = 0, errors = 0;
  int pm[32];
  int sc = 0;
  cprv_hazard_ctrl #(.INSTR_WIDTH(32), .CNT_WIDTH(2), .STALL_CNT_WIDTH(SW)) dut (
    .clk(clk), .rst_n(rst_n), .valid_if_i(valid_if_i), .ready_if_o(ready_if_o),
    .instr_data_if_i(instr_data_if_i), .valid_id_o(valid_id_o), .ready_id_i(ready_id_i),
    .wb_valid_i(wb_valid_i), .wb_rd_addr_i(wb_rd_addr_i), .flush_i(flush_i),
    .stall_o(stall_o), .stall_cnt_o(stall_cnt_o));
  always #5 clk = ~clk;
  function automatic logic [31:0] rt(input logic [6:0] o, input int d, input int a, input int b);
    rt = {7'd0, 5'(b), 5'(a), 3'd0, 5'(d), o};
  endfunction
  function automatic logic [31:0] it(input logic [6:0] o, input int d, input int a);
    it = {12'd1, 5'(a), 3'd0, 5'(d), o};
  endfunction
  function automatic logic [31:0] st(input int b, input int a);
    st = {7'd0, 5'(b), 5'(a), 3'b010, 5'd0, 7'b0100011};
  endfunction
  function automatic void dcd(input logic [31:0] ins, output bit u1, output bit u2, output bit w);
    u1 = 0; u2 = 0; w = 0;
    case (ins[6:0])
      7'b0110011, 7'b0111011: begin u1 = 1; u2 = 1; w = 1; end
      7'b0010011, 7'b0011011, 7'b0000011: begin u1 = 1; w = 1; end
      7'b0100011: begin u1 = 1; u2 = 1; end
      default: ;
    endcase
  endfunction
  function automatic bit mhz(input bit v, input logic [31:0] ins);
    bit u1, u2, w;
    int a, b, d;
    dcd(ins, u1, u2, w);
    a = int'(ins[19:15]); b = int'(ins[24:20]); d = int'(ins[11:7]);
    mhz = v && ((u1 && a != 0 && pm[a] != 0) || (u2 && b != 0 && pm[b] != 0) ||
                (w && d != 0 && pm[d] == MAXP));
  endfunction
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask
  task automatic step(input bit v, input logic [31:0] ins, input bit rdy, input bit wb,
                      input int wa, input bit fl, output bit acc);
    bit h, u1, u2, w, dv;
    int d;
    valid_if_i = v; instr_data_if_i = ins; ready_id_i = rdy;
    wb_valid_i = wb; wb_rd_addr_i = 5'(wa); flush_i = fl;
    #1;
    h = mhz(v, ins);
    chk("stall", 32'(stall_o), 32'(h));
    chk("valid_id", 32'(valid_id_o), 32'(v && !h));
    chk("ready_if", 32'(ready_if_o), 32'(rdy && !h));
    chk("stall_cnt", 32'(stall_cnt_o), 32'(sc));
    dcd(ins, u1, u2, w);
    d = int'(ins[11:7]);
    acc = v && !h && rdy;
    dv = wb && wa != 0 && pm[wa] != 0;
    @(posedge clk);
    if (fl) foreach (pm[i]) pm[i] = 0;
    else begin
      if (acc && w && d != 0) pm[d]++;
      if (dv) pm[wa]--;
    end
    if (h && sc != SMAX) sc++;
    @(negedge clk);
  endtask
  initial begin
    bit a;
    logic [31:0] ins;
    bit v, hold;
    logic [6:0] ops[8];
    ops[0] = 7'b0110011; ops[1] = 7'b0111011; ops[2] = 7'b0010011; ops[3] = 7'b0011011;
    ops[4] = 7'b0000011; ops[5] = 7'b0100011; ops[6] = 7'b1100011; ops[7] = 7'b1101111;
    foreach (pm[i]) pm[i] = 0;
    #3;
    chk("rst_stall", 32'(stall_o), 0);
    chk("rst_valid_id", 32'(valid_id_o), 0);
    chk("rst_cnt", 32'(stall_cnt_o), 0);
    @(negedge clk); rst_n = 1;
    step(1, rt(7'b0110011, 1, 2, 3), 1, 0, 0, 0, a);
    step(1, rt(7'b0110011, 4, 5, 6), 1, 0, 0, 0, a);
    step(1, rt(7'b0110011, 7, 1, 0), 0, 0, 0, 0, a);
    step(1, rt(7'b0110011, 7, 0, 4), 0, 1, 1, 0, a);
    step(1, rt(7'b0110011, 7, 0, 4), 0, 1, 4, 0, a);
    step(1, it(7'b0010011, 5, 0), 1, 0, 0, 0, a);
    step(1, rt(7'b0110011, 6, 5, 5), 1, 0, 0, 0, a);
    step(1, rt(7'b0110011, 6, 5, 5), 1, 0, 0, 0, a);
    step(1, rt(7'b0110011, 6, 5, 5), 1, 1, 5, 0, a);
    step(1, rt(7'b0110011, 6, 5, 5), 1, 0, 0, 0, a);
    step(0, 0, 1, 1, 6, 0, a);
    step(1, it(7'b0010011, 0, 1), 1, 0, 0, 0, a);
    step(1, st(0, 0), 1, 0, 0, 0, a);
    step(1, rt(7'b0110011, 2, 0, 0), 1, 0, 0, 0, a);
    step(1, it(7'b0010011, 8, 0), 1, 0, 0, 0, a);
    step(1, st(8, 2), 1, 0, 0, 0, a);
    step(1, st(8, 2), 1, 1, 8, 0, a);
    step(1, st(8, 2), 1, 1, 2, 0, a);
    repeat (3) step(1, it(7'b0010011, 7, 0), 1, 0, 0, 0, a);
    step(1, it(7'b0010011, 7, 0), 1, 0, 0, 0, a);
    step(1, it(7'b0010011, 7, 0), 1, 1, 7, 0, a);
    step(1, it(7'b0010011, 7, 0), 1, 0, 0, 0, a);
    repeat (3) step(0, 0, 0, 1, 7, 0, a);
    step(1, it(7'b0010011, 9, 0), 1, 0, 0, 0, a);
    step(1, it(7'b0010011, 9, 0), 1, 1, 9, 0, a);
    step(1, rt(7'b0110011, 1, 9, 0), 0, 1, 9, 0, a);
    step(1, rt(7'b0110011, 1, 9, 0), 0, 1, 10, 0, a);
    step(1, rt(7'b0110011, 1, 10, 9), 0, 1, 9, 0, a);
    step(1, rt(7'b0110011, 1, 10, 9), 0, 0, 0, 0, a);
    step(1, it(7'b0010011, 11, 0), 1, 0, 0, 0, a);
    step(1, it(7'b0010011, 12, 0), 1, 0, 0, 0, a);
    step(1, rt(7'b0110011, 13, 11, 12), 1, 0, 0, 1, a);
    step(1, rt(7'b0110011, 13, 11, 12), 0, 0, 0, 0, a);
    step(1, it(7'b0010011, 5, 0), 1, 0, 0, 0, a);
    step(1, rt(7'b0110011, 6, 5, 5), 1, 0, 0, 0, a);
    valid_if_i = 1; instr_data_if_i = rt(7'b0110011, 6, 5, 5);
    #1 rst_n = 0;
    #1;
    chk("async_cnt", 32'(stall_cnt_o), 0);
    chk("async_stall", 32'(stall_o), 0);
    foreach (pm[i]) pm[i] = 0;
    sc = 0;
    @(negedge clk); rst_n = 1;
    hold = 0; v = 0; ins = 0;
    for (int n = 0; n < 2500; n++) begin
      if (!hold) begin
        v = ($urandom_range(0, 9) < 8);
        ins = {$urandom} & 32'hfe0f_8f80;
        ins[6:0] = ops[$urandom_range(0, 7)];
        ins[11:7] = 5'($urandom_range(0, 7));
        ins[19:15] = 5'($urandom_range(0, 7));
        ins[24:20] = 5'($urandom_range(0, 7));
      end
      step(v, ins, $urandom_range(0, 3) != 0, $urandom_range(0, 9) < 4,
           $urandom_range(0, 7), $urandom_range(0, 99) < 3, a);
      hold = v && !a;
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
